// File: rtl/trng_pkg.sv
// Shared constants for the TRNG entropy front-end and the ChaCha20 core's TRNG port.
package trng_pkg;

  localparam int TRNG_WORD_W    = 32;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int RCT_CUTOFF_DEF = 32;

endpackage

// File: rtl/trng_sync_fifo.sv
// Synchronous FIFO with show-ahead head output, synchronous flush and occupancy count.
import trng_pkg::*;

module trng_sync_fifo #(
  parameter int WIDTH = TRNG_WORD_W,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests; a pop frees the slot so a push into a full FIFO still lands.
  always_comb begin
    pop_ok_s  = pop && (count_r != {CW{1'b0}});
    push_ok_s = push && ((count_r != CW'(DEPTH)) || pop_ok_s);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});
  assign count = count_r;

endmodule

// File: rtl/trng_word_buffer.sv
// Entropy front-end: repetition-count health test, von Neumann debiaser, 32-bit packer
// and a word FIFO served over the trng_request/trng_ready handshake.
import trng_pkg::*;

module trng_word_buffer #(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            raw_bit,
  input  logic                            raw_valid,
  input  logic                            health_clr,
  input  logic                            trng_request,
  output logic [TRNG_WORD_W-1:0]          trng_data,
  output logic                            trng_ready,
  output logic                            health_fail,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int IDX_W = $clog2(TRNG_WORD_W);

  logic                   accept_s;
  logic                   trip_s;
  logic [7:0]             run_next_s;
  logic                   deb_valid_s;
  logic                   word_done_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [TRNG_WORD_W-1:0] next_word_s;
  logic [TRNG_WORD_W-1:0] head_s;

  logic                   prev_bit_r;
  logic                   have_prev_r;
  logic [7:0]             run_r;
  logic                   health_fail_r;
  logic                   pair_half_r;
  logic                   first_bit_r;
  logic [TRNG_WORD_W-1:0] word_r;
  logic [IDX_W-1:0]       bit_idx_r;
  logic [TRNG_WORD_W-1:0] trng_data_r;
  logic                   trng_ready_r;

  // Datapath decode: acceptance, RCT run length, debiased bit, push/pop requests.
  always_comb begin
    accept_s = en && raw_valid && !health_fail_r;
    if (have_prev_r && (raw_bit == prev_bit_r)) begin
      run_next_s = run_r + 8'd1;
    end else begin
      run_next_s = 8'd1;
    end
    trip_s      = accept_s && (run_next_s == 8'(RCT_CUTOFF));
    // Pair 10 emits 1 and pair 01 emits 0, i.e. the first bit of an unequal pair.
    deb_valid_s = accept_s && pair_half_r && (first_bit_r != raw_bit);
    next_word_s = word_r;
    next_word_s[bit_idx_r] = first_bit_r;
    word_done_s = deb_valid_s && (bit_idx_r == IDX_W'(TRNG_WORD_W - 1));
    pop_s       = trng_request && !fifo_empty_s && !trng_ready_r && !health_fail_r && !trip_s;
    push_s      = word_done_s && !trip_s && (!fifo_full_s || pop_s);
  end

  // Repetition count test and sticky failure; a trip outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_bit_r    <= 1'b0;
      have_prev_r   <= 1'b0;
      run_r         <= 8'd0;
      health_fail_r <= 1'b0;
    end else if (trip_s) begin
      health_fail_r <= 1'b1;
      have_prev_r   <= 1'b0;
      run_r         <= 8'd0;
    end else if (health_clr) begin
      health_fail_r <= 1'b0;
      have_prev_r   <= 1'b0;
      run_r         <= 8'd0;
    end else if (accept_s) begin
      prev_bit_r  <= raw_bit;
      have_prev_r <= 1'b1;
      run_r       <= run_next_s;
    end
  end

  // Debiaser pairing and word packing; both are discarded on a health trip.
  always_ff @(posedge clk) begin
    if (rst || trip_s) begin
      pair_half_r <= 1'b0;
      first_bit_r <= 1'b0;
      word_r      <= {TRNG_WORD_W{1'b0}};
      bit_idx_r   <= {IDX_W{1'b0}};
    end else if (accept_s) begin
      pair_half_r <= !pair_half_r;
      if (!pair_half_r) first_bit_r <= raw_bit;
      if (deb_valid_s) begin
        word_r    <= word_done_s ? {TRNG_WORD_W{1'b0}} : next_word_s;
        bit_idx_r <= bit_idx_r + IDX_W'(1);
      end
    end
  end

  // Serve: pop the head into the output register with a one-cycle ready pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      trng_data_r  <= {TRNG_WORD_W{1'b0}};
      trng_ready_r <= 1'b0;
    end else begin
      trng_ready_r <= pop_s;
      if (pop_s) trng_data_r <= head_s;
    end
  end

  trng_sync_fifo #(
    .WIDTH (TRNG_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (trip_s),
    .din   (next_word_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count)
  );

  assign trng_data   = trng_data_r;
  assign trng_ready  = trng_ready_r;
  assign health_fail = health_fail_r;

endmodule

// File: tb/tb_trng_word_buffer.sv
// Directed/randomised bench: random words are encoded as raw von Neumann pairs and the
// expected served words come from a queue of the intended words.
module tb_trng_word_buffer;
  import trng_pkg::*;

  localparam int DEPTH  = 16;
  localparam int CUTOFF = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        raw_bit = 1'b0;
  logic        raw_valid = 1'b0;
  logic        health_clr = 1'b0;
  logic        trng_request = 1'b0;
  logic [31:0] trng_data;
  logic        trng_ready;
  logic        health_fail;
  logic [4:0]  fifo_count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  trng_word_buffer #(.FIFO_DEPTH(DEPTH), .RCT_CUTOFF(CUTOFF)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .raw_bit      (raw_bit),
    .raw_valid    (raw_valid),
    .health_clr   (health_clr),
    .trng_request (trng_request),
    .trng_data    (trng_data),
    .trng_ready   (trng_ready),
    .health_fail  (health_fail),
    .fifo_count   (fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One accepted-candidate sample per clock edge.
  task automatic send(input logic b);
    @(negedge clk);
    raw_bit   = b;
    raw_valid = 1'b1;
    @(posedge clk);
    #1 raw_valid = 1'b0;
  endtask

  // Encode a word as 10/01 pairs (LSB first) with random 00/11 filler pairs;
  // optionally pause sampling with en=0 half-way through.
  task automatic encode_word(input logic [31:0] w, input bit gap);
    logic b;
    for (int i = 0; i < 32; i++) begin
      if (gap && i == 16) begin
        en = 1'b0;
        for (int k = 0; k < 10; k++) send(1'($urandom_range(0, 1)));
        en = 1'b1;
      end
      send(w[i]);
      send(!w[i]);
      if ($urandom_range(0, 1) == 1) begin
        b = 1'($urandom_range(0, 1));
        send(b);
        send(b);
      end
    end
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
  endtask

  task automatic serve_one(input string tag, input logic [31:0] expv);
    int at;
    at = -1;
    @(negedge clk);
    trng_request = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (trng_ready) begin
        at = i;
        break;
      end
    end
    trng_request = 1'b0;
    chk({tag, "_latency"}, at, 0);
    if (at >= 0) chk({tag, "_data"}, trng_data, expv);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int last;
    logic [31:0] e;
    logic [31:0] w;

    // Reset with raw_valid toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      raw_valid = ~raw_valid;
      raw_bit   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst       = 1'b0;
    raw_valid = 1'b0;
    @(negedge clk);
    chk("rst_data", trng_data, 32'h0);
    chk("rst_ready", {31'd0, trng_ready}, 32'd0);
    chk("rst_health", {31'd0, health_fail}, 32'd0);
    chk("rst_count", {27'd0, fifo_count}, 32'd0);

    // Pack order: 1,0,0,1 x16 -> alternating 1,0 debiased bits.
    for (int i = 0; i < 16; i++) begin
      send(1'b1); send(1'b0); send(1'b0); send(1'b1);
    end
    @(negedge clk);
    chk("pack_count", {27'd0, fifo_count}, 32'd1);
    serve_one("pack", 32'h5555_5555);

    // Discard pairs: all-ones word with random 00/11 filler.
    encode_word(32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    chk("discard_count", {27'd0, fifo_count}, 32'd1);
    serve_one("discard", exp_q.pop_front());

    // Handshake rate: 4 random words (one with an en=0 pause) then 20 request cycles.
    for (int i = 0; i < 4; i++) encode_word($urandom, (i == 1));
    @(negedge clk);
    chk("hs_count", {27'd0, fifo_count}, 32'd4);
    trng_request = 1'b1;
    pulses = 0;
    last   = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (trng_ready) begin
        if (pulses == 0) chk("hs_first_latency", c, 0);
        else chk("hs_gap", c - last, 2);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("hs_data", trng_data, e);
        last = c;
        pulses++;
      end
    end
    trng_request = 1'b0;
    chk("hs_pulses", pulses, 4);
    chk("hs_empty", {27'd0, fifo_count}, 32'd0);

    // Overflow: 17 words, the 17th is dropped.
    for (int i = 0; i < 17; i++) begin
      w = (i == 0) ? 32'h0 : ((i == 16) ? 32'hFFFF_FFFF : $urandom);
      encode_word(w, 1'b0);
    end
    @(negedge clk);
    chk("ovf_count", {27'd0, fifo_count}, 32'd16);
    for (int i = 0; i < 16; i++) serve_one("ovf_read", exp_q.pop_front());
    @(negedge clk);
    chk("ovf_drained", {27'd0, fifo_count}, 32'd0);

    // Health: 3 words buffered, then a 0 followed by CUTOFF ones.
    for (int i = 0; i < 3; i++) encode_word($urandom, 1'b0);
    @(negedge clk);
    chk("hl_count", {27'd0, fifo_count}, 32'd3);
    send(1'b0);
    for (int i = 0; i < CUTOFF - 1; i++) send(1'b1);
    @(negedge clk);
    chk("hl_below_cutoff", {31'd0, health_fail}, 32'd0);
    send(1'b1);
    @(negedge clk);
    chk("hl_trip", {31'd0, health_fail}, 32'd1);
    chk("hl_flushed", {27'd0, fifo_count}, 32'd0);
    exp_q.delete();
    trng_request = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (trng_ready) pulses++;
    end
    trng_request = 1'b0;
    chk("hl_no_pulse", pulses, 0);
    health_clr = 1'b1;
    @(negedge clk);
    health_clr = 1'b0;
    chk("hl_cleared", {31'd0, health_fail}, 32'd0);
    encode_word($urandom, 1'b0);
    @(negedge clk);
    chk("hl_recover_count", {27'd0, fifo_count}, 32'd1);
    serve_one("hl_recover", exp_q.pop_front());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trng_word_buffer.md
# trng_word_buffer

Entropy front-end that feeds the ChaCha20 core's TRNG port. Samples a raw 1-bit entropy source, checks it with a repetition-count health test, debiases it (von Neumann), and packs the result into 32-bit words. Words are queued in a FIFO and served to the core one at a time over the `trng_request`/`trng_ready` handshake, which the core uses to acquire key, nonce and counter words.

## Interface
- `FIFO_DEPTH`, 16: words buffered; power of two, ≥2.
- `RCT_CUTOFF`, 32: consecutive identical raw bits that trip the health test; range 2..255.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  sampling enable; when 0, `raw_valid` is ignored.
- `raw_bit`  in  1  raw entropy sample.
- `raw_valid`  in  1  `raw_bit` is valid this cycle.
- `health_clr`  in  1  one-cycle pulse that clears a latched health failure.
- `trng_request`  in  1  core wants a word; level, held until served.
- `trng_data`  out  32  served word.
- `trng_ready`  out  1  one-cycle pulse: `trng_data` is valid.
- `health_fail`  out  1  sticky health-test failure.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  words currently buffered.

## Operation
- **Reset:** all outputs are 0 (`trng_data`=0, `trng_ready`=0, `health_fail`=0, `fifo_count`=0). The FIFO, packer, debiaser and RCT counter are cleared. Reset in mid-operation discards every buffered word and any partial word.
- **Sample acceptance:** a sample is accepted when `en && raw_valid && !health_fail`.
- **RCT (repetition count test):**
  - Runs on accepted raw bits, before debiasing.
  - The run counter restarts at 1 when the bit differs from the previous bit (or on the first bit after reset/clear), and increments when it is the same.
  - When the run length reaches `RCT_CUTOFF`, `health_fail` is set on that edge.
- **Debiaser:**
  - Accepted bits are paired in order: first bit of a pair, then second.
  - Pair 10 emits 1; pair 01 emits 0; pairs 00 and 11 emit nothing.
  - At most one debiased bit per cycle.
- **Packer:**
  - The nth debiased bit of a word goes to bit n, so the first bit lands in bit 0.
  - On the 32nd bit, the word is pushed into the FIFO and the packer restarts at bit 0.
  - If the FIFO is full, the completed word is dropped. The source is never stalled.
- **Serving:**
  - At an edge where `trng_request && fifo_count!=0 && !trng_ready && !health_fail`, the FIFO head is popped into `trng_data` and `trng_ready`=1.
  - Otherwise `trng_ready`=0.
  - `trng_data` holds the last served word until the next pop.
- **Simultaneous push and pop:** allowed, including when the FIFO is full. In that case the pop frees the slot and the push succeeds, leaving `fifo_count` unchanged.
- **Health failure:**
  - On the edge that sets `health_fail`, the FIFO, packer and debiaser are flushed; `fifo_count` reads 0 next cycle.
  - No `trng_ready` pulse is produced while `health_fail`=1.
  - `health_clr` clears `health_fail` and the RCT counter.
  - If a failure trip and `health_clr` occur in the same cycle, the failure wins.
- **`en`=0:** no sampling. Buffered words are retained and serving continues. The partial word and any pending pair bit are kept.

## Timing
- **Serve latency:** `trng_request` seen with a non-empty FIFO at edge N gives `trng_ready`=1 in the cycle after edge N.
- **Serve rate:** at most one word every 2 cycles. The core must drop `trng_request` in the `trng_ready` cycle if it needs no more words.
- **Push to count:** the sample that completes a word is pushed at its accept edge; `fifo_count` shows the new value in the next cycle.
  - A push into an empty FIFO can be served, at the earliest, from the following edge.
- **Source rate:** a word needs at least 64 accepted raw samples.
- **RCT trip:** `health_fail` rises in the cycle after the edge on which the `RCT_CUTOFF`-th identical bit is accepted.

## Structure
- Package `trng_pkg`:
  - `TRNG_WORD_W`=32.
  - Default `FIFO_DEPTH` and `RCT_CUTOFF` constants.
  - Shared with the ChaCha20 core for `trng_data` width.
- Sub-module `trng_sync_fifo`:
  - Parameterised width and depth, synchronous, show-ahead head output.
  - Ports: `push`, `pop`, `flush`, `full`, `empty`, `count`.
- The top level holds the RCT, debiaser, packer and serve logic.

## Test plan
- **Reset:** hold `rst` 3 cycles with `raw_valid` toggling → all outputs 0, `fifo_count`=0 after release.
- **Pack order:** feed raw 1,0,0,1 repeated 16 times (64 samples) → `fifo_count`=1. Then assert `trng_request` → one `trng_ready` pulse with `trng_data`=0x55555555.
- **Discard pairs:** interleave 11 and 00 pairs between 32 pairs of 10 → exactly one word, 0xFFFFFFFF; 00/11 pairs do not change the result.
- **Handshake rate:** with 4 words buffered, hold `trng_request` for 20 cycles → exactly 4 pulses, 2 cycles apart, in push order. `trng_ready` then stays 0 until a new word arrives.
- **Overflow:** push 17 words (first words 0x00000000, then 0xFFFFFFFF) with no reads → `fifo_count`=16, the 17th word is dropped, and a read-out returns the first 16 in order.
- **Health:** feed 32 consecutive raw 1s with 3 words buffered → `health_fail`=1, `fifo_count`=0, and `trng_request` gets no pulse. Pulse `health_clr` → `health_fail`=0 and a normal word is produced again.
